// File: rtl/ddsm_pkg.sv
// Shared definitions for the DDSM phase-adjust path: sequencer state
// encoding, adder field width and the chunk clamp limits.
package ddsm_pkg;

    // Width of the phase adder's adjust field (two's complement).
    localparam int PHASEADD_W = 12;

    // Default largest chunk magnitude the adder is fed per enable pulse.
    localparam int CHUNK_MAX_DEF = 2047;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } seq_state_t;

    // Upper clamp limit for a chunk.
    function automatic int chunk_pos_lim(input int chunk_max);
        return chunk_max;
    endfunction

    // Lower clamp limit for a chunk. It is one step further from zero than
    // the upper limit so that a full-scale negative field value is reachable.
    function automatic int chunk_neg_lim(input int chunk_max);
        return -(chunk_max + 1);
    endfunction

endpackage

// File: rtl/phase_step_sequencer_if.sv
// Valid/ready request channel carrying a signed phase step into the
// sequencer. The master is the requester; the slave is the sequencer.
interface phase_step_sequencer_if #(
    parameter int P_STEP_W = 16
);
    logic signed [P_STEP_W-1:0] i_step;
    logic                       i_step_valid;
    logic                       o_step_ready;

    modport master (
        output i_step,
        output i_step_valid,
        input  o_step_ready
    );

    modport slave (
        input  i_step,
        input  i_step_valid,
        output o_step_ready
    );
endinterface

// File: rtl/phase_chunk_sel.sv
// Combinational chunk selector: clamps the remaining phase step into the
// range one adder pulse may carry and flags an exhausted remainder.
module phase_chunk_sel
    import ddsm_pkg::*;
#(
    parameter int P_STEP_W    = 16,
    parameter int P_CHUNK_MAX = CHUNK_MAX_DEF
) (
    input  logic signed [P_STEP_W:0]   i_rem,
    output logic signed [P_STEP_W:0]   o_chunk_ext,
    output logic [PHASEADD_W-1:0]      o_chunk,
    output logic                       o_rem_zero
);

    localparam logic signed [P_STEP_W:0] LIM_POS = (P_STEP_W+1)'(chunk_pos_lim(P_CHUNK_MAX));
    localparam logic signed [P_STEP_W:0] LIM_NEG = (P_STEP_W+1)'(chunk_neg_lim(P_CHUNK_MAX));

    // Saturate the remainder to the legal chunk range; both operands are signed.
    always_comb begin
        if (i_rem > LIM_POS) begin
            o_chunk_ext = LIM_POS;
        end else if (i_rem < LIM_NEG) begin
            o_chunk_ext = LIM_NEG;
        end else begin
            o_chunk_ext = i_rem;
        end
    end

    // The clamp range fits the adder field, so truncation is lossless.
    assign o_chunk    = o_chunk_ext[PHASEADD_W-1:0];
    assign o_rem_zero = (i_rem == '0);

endmodule

// File: rtl/phase_step_sequencer.sv
// Splits a signed phase-step request into clamped chunks and delivers each
// one to the DDSM phase adder as a single enable pulse, with the chunk value
// set up a cycle ahead and held stable for the whole pulse.
module phase_step_sequencer
    import ddsm_pkg::*;
#(
    parameter int P_STEP_W    = 16,
    parameter int P_CHUNK_MAX = CHUNK_MAX_DEF,
    parameter int P_HOLD      = 3,
    parameter int P_GAP       = 2
) (
    input  logic                   i_clk,
    input  logic                   i_ff_rst,
    input  logic                   i_mod_run,
    phase_step_sequencer_if.slave  s_step,
    output logic                   o_phaseadjusten,
    output logic [PHASEADD_W-1:0]  o_phaseadd,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [7:0]             o_retry_cnt
);

    localparam logic [7:0] HOLD_LAST = 8'(P_HOLD - 1);
    localparam logic [7:0] GAP_LAST  = 8'(P_GAP - 1);
    // The adder captures during the first two enable cycles only.
    localparam logic [7:0] RUN_WIN   = 8'd2;

    seq_state_t                r_state;
    logic [7:0]                r_cnt;
    logic signed [P_STEP_W:0]  r_rem;
    logic                      r_run_ok;
    logic                      r_phaseadjusten;
    logic [PHASEADD_W-1:0]     r_phaseadd;
    logic                      r_done;
    logic [7:0]                r_retry_cnt;

    seq_state_t                w_state_nxt;
    logic [7:0]                w_cnt_nxt;
    logic signed [P_STEP_W:0]  w_rem_nxt;
    logic                      w_run_ok_nxt;
    logic                      w_phaseadjusten_nxt;
    logic [PHASEADD_W-1:0]     w_phaseadd_nxt;
    logic                      w_done_nxt;
    logic [7:0]                w_retry_nxt;

    logic                      w_idle;
    logic                      w_accept;
    logic signed [P_STEP_W:0]  w_step_ext;
    logic signed [P_STEP_W:0]  w_sel_in;
    logic signed [P_STEP_W:0]  w_chunk_ext;
    logic [PHASEADD_W-1:0]     w_chunk;
    logic                      w_sel_zero;
    logic                      w_run_ok_now;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = w_idle & s_step.i_step_valid;
    assign w_step_ext = {s_step.i_step[P_STEP_W-1], s_step.i_step};

    // In IDLE the selector looks at the incoming request so the first chunk
    // can be registered on the accept edge and be on o_phaseadd in SETUP.
    assign w_sel_in = w_idle ? w_step_ext : r_rem;

    phase_chunk_sel #(
        .P_STEP_W    (P_STEP_W),
        .P_CHUNK_MAX (P_CHUNK_MAX)
    ) u_chunk_sel (
        .i_rem       (w_sel_in),
        .o_chunk_ext (w_chunk_ext),
        .o_chunk     (w_chunk),
        .o_rem_zero  (w_sel_zero)
    );

    // Run flag accumulated over the capture window, including this cycle's
    // sample when still inside the window.
    assign w_run_ok_now = r_run_ok & ((r_cnt >= RUN_WIN) | i_mod_run);

    // Next-state and next-output logic for the chunk sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rem_nxt      = r_rem;
        w_run_ok_nxt   = r_run_ok;
        w_phaseadd_nxt = r_phaseadd;
        w_done_nxt     = 1'b0;
        w_retry_nxt    = r_retry_cnt;

        case (r_state)
            ST_IDLE: begin
                w_phaseadd_nxt = '0;
                if (w_accept) begin
                    if (w_sel_zero) begin
                        // Nothing to apply: acknowledge without a pulse.
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = ST_SETUP;
                        w_rem_nxt      = w_step_ext;
                        w_phaseadd_nxt = w_chunk;
                    end
                end
            end

            ST_SETUP: begin
                w_state_nxt  = ST_PULSE;
                w_cnt_nxt    = '0;
                w_run_ok_nxt = 1'b1;
            end

            ST_PULSE: begin
                w_run_ok_nxt = w_run_ok_now;
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = '0;
                    if (w_run_ok_now) begin
                        w_rem_nxt = r_rem - w_chunk_ext;
                    end else if (r_retry_cnt != 8'hFF) begin
                        w_retry_nxt = r_retry_cnt + 8'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_sel_zero) begin
                        w_state_nxt    = ST_IDLE;
                        w_done_nxt     = 1'b1;
                        w_phaseadd_nxt = '0;
                    end else begin
                        // Remainder already reflects the last pulse, so this
                        // is either the next chunk or a retry of the same one.
                        w_state_nxt    = ST_SETUP;
                        w_phaseadd_nxt = w_chunk;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            default: begin
                w_state_nxt    = ST_IDLE;
                w_phaseadd_nxt = '0;
            end
        endcase

        w_phaseadjusten_nxt = (w_state_nxt == ST_PULSE);
    end

    // State and registered outputs; reset clears the enable immediately.
    always_ff @(posedge i_clk or posedge i_ff_rst) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (i_ff_rst) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_rem           <= '0;
            r_run_ok        <= 1'b0;
            r_phaseadjusten <= 1'b0;
            r_phaseadd      <= '0;
            r_done          <= 1'b0;
            r_retry_cnt     <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_rem           <= w_rem_nxt;
            r_run_ok        <= w_run_ok_nxt;
            r_phaseadjusten <= w_phaseadjusten_nxt;
            r_phaseadd      <= w_phaseadd_nxt;
            r_done          <= w_done_nxt;
            r_retry_cnt     <= w_retry_nxt;
        end
    end

    assign s_step.o_step_ready = w_idle;
    assign o_busy              = ~w_idle;
    assign o_phaseadjusten     = r_phaseadjusten;
    assign o_phaseadd          = r_phaseadd;
    assign o_done              = r_done;
    assign o_retry_cnt         = r_retry_cnt;

endmodule

// File: tb/tb_phase_step_sequencer.sv
// Directed bench for phase_step_sequencer: a table of requests with
// hand-computed chunk sequences and completion cycles, plus hand-written
// sequences for busy handling, asynchronous reset and retry saturation.
module tb_phase_step_sequencer;

    localparam int STEP_W = 16;
    localparam int HOLD   = 3;
    localparam int GAP    = 2;

    logic        i_clk;
    logic        i_ff_rst;
    logic        mod_run;
    logic        o_phaseadjusten;
    logic [11:0] o_phaseadd;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_retry_cnt;

    phase_step_sequencer_if #(.P_STEP_W(STEP_W)) u_if ();

    phase_step_sequencer #(
        .P_STEP_W    (STEP_W),
        .P_CHUNK_MAX (2047),
        .P_HOLD      (HOLD),
        .P_GAP       (GAP)
    ) dut (
        .i_clk           (i_clk),
        .i_ff_rst        (i_ff_rst),
        .i_mod_run       (mod_run),
        .s_step          (u_if.slave),
        .o_phaseadjusten (o_phaseadjusten),
        .o_phaseadd      (o_phaseadd),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_retry_cnt     (o_retry_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One request per record; run_low is the cycle (accept = 0) in which
    // i_mod_run is held low, -1 for never.
    typedef struct {
        logic signed [15:0] step;
        int                 run_low;
        int                 n;
        logic [11:0]        first;
        logic [11:0]        last;
        int                 done;
        int                 retries;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int          edge_cyc   [32];
    logic [11:0] edge_chunk [32];
    int          n_edges;
    int          done_cyc;
    int          shape_err;
    int          exp_retry;

    // Issue one request and record enable rising edges, the chunk on each,
    // the o_done cycle and any pulse-shape violations, within max_cyc cycles.
    task automatic run_req(input logic signed [15:0] step, input int run_low_cyc, input int max_cyc);
        int          hi_len;
        logic        prev_en;
        logic [11:0] prev_pa;
        n_edges   = 0;
        done_cyc  = -1;
        shape_err = 0;
        hi_len    = 0;
        @(negedge i_clk);
        check("ready_before_accept", u_if.o_step_ready, 1);
        u_if.i_step       = step;
        u_if.i_step_valid = 1'b1;
        mod_run           = 1'b1;
        prev_en = o_phaseadjusten;
        prev_pa = o_phaseadd;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge i_clk);
            u_if.i_step_valid = 1'b0;
            mod_run = (c == run_low_cyc) ? 1'b0 : 1'b1;
            if (o_phaseadjusten && !prev_en) begin
                if (n_edges < 32) begin
                    edge_cyc[n_edges]   = c;
                    edge_chunk[n_edges] = o_phaseadd;
                end
                n_edges++;
                // The chunk must already be on the bus in the setup cycle.
                if (o_phaseadd !== prev_pa) shape_err++;
                hi_len = 0;
            end
            if (o_phaseadjusten) begin
                hi_len++;
                if (n_edges >= 1 && n_edges <= 32 && o_phaseadd !== edge_chunk[n_edges-1]) shape_err++;
            end
            if (!o_phaseadjusten && prev_en && hi_len != HOLD) shape_err++;
            if (o_done) begin
                done_cyc = c;
                if (!u_if.o_step_ready || o_busy || o_phaseadjusten) shape_err++;
                break;
            end
            prev_en = o_phaseadjusten;
            prev_pa = o_phaseadd;
        end
    endtask

    initial begin
        int err;
        int nd;
        int d_cyc [4];

        vecs[0]  = '{16'sd100,    -1,  1, 12'h064, 12'h064,  7, 0};
        vecs[1]  = '{16'sd5000,   -1,  3, 12'h7FF, 12'h38A, 19, 0};
        vecs[2]  = '{-16'sd3000,  -1,  2, 12'h800, 12'hC48, 13, 0};
        vecs[3]  = '{16'sd0,      -1,  0, 12'h000, 12'h000,  1, 0};
        vecs[4]  = '{16'sd2047,   -1,  1, 12'h7FF, 12'h7FF,  7, 0};
        vecs[5]  = '{-16'sd2048,  -1,  1, 12'h800, 12'h800,  7, 0};
        vecs[6]  = '{16'sd2048,   -1,  2, 12'h7FF, 12'h001, 13, 0};
        vecs[7]  = '{-16'sd2049,  -1,  2, 12'h800, 12'hFFF, 13, 0};
        vecs[8]  = '{-16'sd1,     -1,  1, 12'hFFF, 12'hFFF,  7, 0};
        vecs[9]  = '{-16'sd32768, -1, 16, 12'h800, 12'h800, 97, 0};
        vecs[10] = '{16'sd100,     3,  2, 12'h064, 12'h064, 13, 1};
        vecs[11] = '{16'sd100,     2,  2, 12'h064, 12'h064, 13, 1};
        vecs[12] = '{16'sd100,     4,  1, 12'h064, 12'h064,  7, 0};
        vecs[13] = '{16'sd5000,    9,  4, 12'h7FF, 12'h38A, 25, 1};
        vecs[14] = '{16'sd32767,  -1, 17, 12'h7FF, 12'h00F, 103, 0};

        i_ff_rst          = 1'b1;
        mod_run           = 1'b1;
        u_if.i_step       = '0;
        u_if.i_step_valid = 1'b0;
        exp_retry         = 0;

        // Reset state.
        @(negedge i_clk);
        check("rst_en",      o_phaseadjusten, 0);
        check("rst_phaseadd", o_phaseadd,     0);
        check("rst_busy",    o_busy,          0);
        check("rst_done",    o_done,          0);
        check("rst_retry",   o_retry_cnt,     0);
        check("rst_ready",   u_if.o_step_ready, 1);
        @(negedge i_clk);
        i_ff_rst = 1'b0;
        @(negedge i_clk);

        // Table-driven requests.
        for (int v = 0; v < NV; v++) begin
            run_req(vecs[v].step, vecs[v].run_low, 120);
            check($sformatf("v%0d_edges", v), n_edges, vecs[v].n);
            check($sformatf("v%0d_done_cycle", v), done_cyc, vecs[v].done);
            check($sformatf("v%0d_shape", v), shape_err, 0);
            if (n_edges > 0 && n_edges <= 32) begin
                check($sformatf("v%0d_first_edge", v), edge_cyc[0], 2);
                for (int i = 0; i < n_edges; i++) begin
                    if (i > 0) check($sformatf("v%0d_spacing%0d", v, i), edge_cyc[i] - edge_cyc[i-1], 6);
                    check($sformatf("v%0d_chunk%0d", v, i), edge_chunk[i],
                          (i == vecs[v].n - 1) ? vecs[v].last : vecs[v].first);
                end
            end
            exp_retry += vecs[v].retries;
            @(negedge i_clk);
            check($sformatf("v%0d_done_one_cycle", v), o_done, 0);
            check($sformatf("v%0d_retry_cnt", v), o_retry_cnt, exp_retry);
            check($sformatf("v%0d_idle_phaseadd", v), o_phaseadd, 0);
        end

        // A second request held valid while busy is taken only once IDLE.
        err = 0;
        nd  = 0;
        n_edges = 0;
        @(negedge i_clk);
        u_if.i_step       = 16'sd100;
        u_if.i_step_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            logic prev_en;
            prev_en = o_phaseadjusten;
            @(negedge i_clk);
            if (c == 1) u_if.i_step = 16'sd2047;
            if (c == 8) u_if.i_step_valid = 1'b0;
            if (c <= 6 && u_if.o_step_ready) err++;
            if (o_phaseadjusten && !prev_en && n_edges < 32) begin
                edge_cyc[n_edges]   = c;
                edge_chunk[n_edges] = o_phaseadd;
                n_edges++;
            end
            if (o_done) begin
                if (nd < 4) d_cyc[nd] = c;
                nd++;
            end
        end
        check("busy_not_ready", err, 0);
        check("busy_edges", n_edges, 2);
        check("busy_done_count", nd, 2);
        if (n_edges == 2) begin
            check("busy_edge0_cyc",   edge_cyc[0],   2);
            check("busy_edge0_chunk", edge_chunk[0], 12'h064);
            check("busy_edge1_cyc",   edge_cyc[1],   9);
            check("busy_edge1_chunk", edge_chunk[1], 12'h7FF);
        end
        if (nd == 2) begin
            check("busy_done0_cyc", d_cyc[0], 7);
            check("busy_done1_cyc", d_cyc[1], 14);
        end

        // Asynchronous reset in the middle of a pulse.
        @(negedge i_clk);
        u_if.i_step       = 16'sd5000;
        u_if.i_step_valid = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge i_clk);
            u_if.i_step_valid = 1'b0;
        end
        check("midpulse_en_high", o_phaseadjusten, 1);
        #2 i_ff_rst = 1'b1;
        #1;
        check("async_rst_en",       o_phaseadjusten, 0);
        check("async_rst_phaseadd", o_phaseadd,      0);
        check("async_rst_busy",     o_busy,          0);
        check("async_rst_ready",    u_if.o_step_ready, 1);
        check("async_rst_retry",    o_retry_cnt,     0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_ff_rst  = 1'b0;
        exp_retry = 0;
        err = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge i_clk);
            if (o_done || o_phaseadjusten || o_busy) err++;
        end
        check("after_rst_quiet", err, 0);

        // Retry counter saturation with the modulator stopped.
        @(negedge i_clk);
        mod_run           = 1'b0;
        u_if.i_step       = 16'sd100;
        u_if.i_step_valid = 1'b1;
        for (int c = 1; c <= 1700; c++) begin
            @(negedge i_clk);
            u_if.i_step_valid = 1'b0;
        end
        check("sat_retry", o_retry_cnt, 8'd255);
        check("sat_busy",  o_busy,      1);
        mod_run = 1'b1;
        err = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (o_done) begin
                err = 0;
                break;
            end
        end
        check("sat_done_seen", err, 0);
        check("sat_retry_hold", o_retry_cnt, 8'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
